// File: rtl/router_fsm_ctrl_if.sv
// Handshake/strobe bundle between the router controller and its neighbours.
// master drives the controller inputs; slave is the controller itself.
interface router_fsm_ctrl_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic       timeout_err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy, timeout_err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy, timeout_err
    );
endinterface

// File: rtl/router_fsm_ctrl.sv
// Moore packet sequencer for the 1x3 router. Define ROUTER_WAIT_TIMEOUT_EN to bound
// the time spent waiting for a busy destination FIFO to drain (WAIT_TIMEOUT cycles).
module router_fsm_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    router_fsm_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StDecodeAddress    = 3'd0,
        StLoadFirstData    = 3'd1,
        StLoadData         = 3'd2,
        StFifoFull         = 3'd3,
        StLoadAfterFull    = 3'd4,
        StLoadParity       = 3'd5,
        StCheckParityError = 3'd6,
        StWaitTillEmpty    = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] empty_vec;
    logic [3:0] soft_vec;
    logic       hdr_ok;
    logic       sel_empty;
    logic       sel_soft_reset;

    // Index 3 is padded so an address of 3 can never select a live flag.
    assign empty_vec      = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_vec       = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign hdr_ok         = bus.pkt_valid && (bus.data_in != 2'd3);
    assign sel_empty      = empty_vec[addr_q];
    assign sel_soft_reset = soft_vec[addr_q];

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(WAIT_TIMEOUT);

    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_hit;
    logic            timeout_err_q;

    // Held at zero outside the wait state, so it is cleared on every entry.
    assign wait_cnt_d = (state_q == StWaitTillEmpty) ? wait_cnt_q + CntW'(1) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_hit;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StDecodeAddress;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (state_q != StDecodeAddress && sel_soft_reset) begin
            state_d = StDecodeAddress;
        end else begin
            unique case (state_q)
                StDecodeAddress: begin
                    if (hdr_ok) begin
                        addr_d  = bus.data_in;
                        state_d = empty_vec[bus.data_in] ? StLoadFirstData : StWaitTillEmpty;
                    end
                end
                StLoadFirstData: state_d = StLoadData;
                StLoadData: begin
                    // A full FIFO beats pkt_valid falling in the same cycle.
                    if (bus.fifo_full)       state_d = StFifoFull;
                    else if (!bus.pkt_valid) state_d = StLoadParity;
                end
                StFifoFull: begin
                    if (!bus.fifo_full) state_d = StLoadAfterFull;
                end
                StLoadAfterFull: begin
                    if (bus.parity_done)        state_d = StDecodeAddress;
                    else if (bus.low_pkt_valid) state_d = StLoadParity;
                    else                        state_d = StLoadData;
                end
                StLoadParity: state_d = StCheckParityError;
                StCheckParityError: begin
                    state_d = bus.fifo_full ? StFifoFull : StDecodeAddress;
                end
                StWaitTillEmpty: begin
`ifdef ROUTER_WAIT_TIMEOUT_EN
                    if (sel_empty) begin
                        state_d = StLoadFirstData;
                    end else if (wait_cnt_q == CntW'(WAIT_TIMEOUT - 1)) begin
                        state_d     = StDecodeAddress;
                        timeout_hit = 1'b1;
                    end
`else
                    if (sel_empty) state_d = StLoadFirstData;
`endif
                end
            endcase
        end
    end

    always_comb begin
        bus.detect_add    = (state_q == StDecodeAddress);
        bus.lfd_state     = (state_q == StLoadFirstData);
        bus.ld_state      = (state_q == StLoadData);
        bus.laf_state     = (state_q == StLoadAfterFull);
        bus.full_state    = (state_q == StFifoFull);
        bus.write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                            (state_q == StLoadAfterFull);
        bus.rst_int_reg   = (state_q == StCheckParityError);
        bus.busy          = (state_q != StDecodeAddress) && (state_q != StLoadData);
`ifdef ROUTER_WAIT_TIMEOUT_EN
        bus.timeout_err   = timeout_err_q;
`else
        bus.timeout_err   = 1'b0;
`endif
    end

endmodule
